// File: rtl/kronos_decode.sv
`default_nettype none
// ============================================================================
//  Module   : kronos_decode
//  Purpose  : RV32I instruction decode stage of the Kronos core. Accepts a
//             {pc, ir} packet from fetch, reads the register file (with
//             same-cycle writeback forwarding), decodes ALU operands,
//             immediate and control flags, and presents one registered
//             decode packet per instruction to execute.
//  Ports    :
//    clk, rst                     clock, synchronous active-high reset
//    fetch_pc/ir/vld, fetch_rdy   incoming instruction stream
//    regrd_rs1/rs2_addr/data      asynchronous register file read
//    regwr_en/sel/data            writeback port, forwarded into decode
//    flush                        kill held and incoming instruction
//    decode_*                     registered decode packet to execute
//    decode_vld, decode_rdy       outgoing handshake
//  Revision : 1.0  initial release
// ============================================================================
module kronos_decode (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_ir,
  input  logic        fetch_vld,
  output logic        fetch_rdy,
  // register file
  output logic [4:0]  regrd_rs1_addr,
  output logic [4:0]  regrd_rs2_addr,
  input  logic [31:0] regrd_rs1_data,
  input  logic [31:0] regrd_rs2_data,
  input  logic        regwr_en,
  input  logic [4:0]  regwr_sel,
  input  logic [31:0] regwr_data,
  // control
  input  logic        flush,
  // execute side
  output logic [31:0] decode_pc,
  output logic [31:0] decode_ir,
  output logic [31:0] decode_op1,
  output logic [31:0] decode_op2,
  output logic [31:0] decode_rs1_data,
  output logic [31:0] decode_rs2_data,
  output logic [31:0] decode_imm,
  output logic [4:0]  decode_rd,
  output logic        decode_rd_we,
  output logic [3:0]  decode_aluop,
  output logic        decode_is_load,
  output logic        decode_is_store,
  output logic        decode_is_branch,
  output logic        decode_is_jump,
  output logic        decode_illegal,
  output logic        decode_vld,
  input  logic        decode_rdy
);

  // Full 7-bit opcodes; including ir[1:0] means any non-32-bit encoding
  // falls through to the illegal default.
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] c_F7_ZERO = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = fetch_ir[6:0];
  assign w_funct3 = fetch_ir[14:12];
  assign w_funct7 = fetch_ir[31:25];
  assign w_rd     = fetch_ir[11:7];

  assign w_imm_i = {{20{fetch_ir[31]}}, fetch_ir[31:20]};
  assign w_imm_s = {{20{fetch_ir[31]}}, fetch_ir[31:25], fetch_ir[11:7]};
  assign w_imm_b = {{19{fetch_ir[31]}}, fetch_ir[31], fetch_ir[7],
                    fetch_ir[30:25], fetch_ir[11:8], 1'b0};
  assign w_imm_u = {fetch_ir[31:12], 12'h000};
  assign w_imm_j = {{11{fetch_ir[31]}}, fetch_ir[31], fetch_ir[19:12],
                    fetch_ir[20], fetch_ir[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // Register read with writeback forwarding. x0 reads as zero, which also
  // guarantees a writeback to x0 is never forwarded.
  // --------------------------------------------------------------------------
  logic [31:0] w_rs1, w_rs2;

  assign regrd_rs1_addr = fetch_ir[19:15];
  assign regrd_rs2_addr = fetch_ir[24:20];

  always_comb begin
    w_rs1 = regrd_rs1_data;
    if (regrd_rs1_addr == 5'd0)
      w_rs1 = 32'h0;
    else if (regwr_en && (regwr_sel == regrd_rs1_addr))
      w_rs1 = regwr_data;
  end

  always_comb begin
    w_rs2 = regrd_rs2_data;
    if (regrd_rs2_addr == 5'd0)
      w_rs2 = 32'h0;
    else if (regwr_en && (regwr_sel == regrd_rs2_addr))
      w_rs2 = regwr_data;
  end

  // --------------------------------------------------------------------------
  // Opcode decode
  // --------------------------------------------------------------------------
  logic [31:0] w_op1, w_op2, w_imm;
  logic [3:0]  w_aluop;
  logic        w_rd_we, w_is_load, w_is_store, w_is_branch, w_is_jump;
  logic        w_illegal;

  always_comb begin
    w_op1       = 32'h0;
    w_op2       = 32'h0;
    w_imm       = 32'h0;
    w_aluop     = 4'b0000;
    w_rd_we     = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_illegal   = 1'b0;

    case (w_opcode)
      c_OPC_LUI: begin
        w_imm   = w_imm_u;
        w_op2   = w_imm_u;
        w_rd_we = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_imm   = w_imm_u;
        w_op1   = fetch_pc;
        w_op2   = w_imm_u;
        w_rd_we = 1'b1;
      end
      c_OPC_JAL: begin
        // Link value pc+4 is computed by the ALU; target uses imm.
        w_imm     = w_imm_j;
        w_op1     = fetch_pc;
        w_op2     = 32'd4;
        w_rd_we   = 1'b1;
        w_is_jump = 1'b1;
      end
      c_OPC_JALR: begin
        w_imm     = w_imm_i;
        w_op1     = fetch_pc;
        w_op2     = 32'd4;
        w_rd_we   = 1'b1;
        w_is_jump = 1'b1;
        if (w_funct3 != 3'b000) w_illegal = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_imm       = w_imm_b;
        w_op1       = w_rs1;
        w_op2       = w_rs2;
        w_aluop     = {1'b0, w_funct3};
        w_is_branch = 1'b1;
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
      end
      c_OPC_LOAD: begin
        w_imm     = w_imm_i;
        w_op1     = w_rs1;
        w_op2     = w_imm_i;
        w_rd_we   = 1'b1;
        w_is_load = 1'b1;
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
          w_illegal = 1'b1;
      end
      c_OPC_STORE: begin
        w_imm      = w_imm_s;
        w_op1      = w_rs1;
        w_op2      = w_imm_s;
        w_is_store = 1'b1;
        if (w_funct3 >= 3'b011) w_illegal = 1'b1;
      end
      c_OPC_OPIMM: begin
        w_imm   = w_imm_i;
        w_op1   = w_rs1;
        w_op2   = w_imm_i;
        w_rd_we = 1'b1;
        // Only the right shifts carry the arithmetic bit; other funct3
        // values use ir[30] as part of the immediate.
        w_aluop = {(w_funct3 == 3'b101) ? fetch_ir[30] : 1'b0, w_funct3};
        if (w_funct3 == 3'b001 && w_funct7 != c_F7_ZERO)
          w_illegal = 1'b1;
        if (w_funct3 == 3'b101 && w_funct7 != c_F7_ZERO && w_funct7 != c_F7_ALT)
          w_illegal = 1'b1;
      end
      c_OPC_OP: begin
        w_op1   = w_rs1;
        w_op2   = w_rs2;
        w_aluop = {fetch_ir[30], w_funct3};
        w_rd_we = 1'b1;
        if (w_funct7 != c_F7_ZERO && w_funct7 != c_F7_ALT)
          w_illegal = 1'b1;
        else if (w_funct7 == c_F7_ALT && w_funct3 != 3'b000 && w_funct3 != 3'b101)
          w_illegal = 1'b1;
      end
      c_OPC_MISC, c_OPC_SYSTEM: begin
        // Passed through untouched for later stages.
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_illegal) begin
      w_rd_we     = 1'b0;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jump   = 1'b0;
    end
    if (w_rd == 5'd0) w_rd_we = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Handshake and output packet register
  // --------------------------------------------------------------------------
  logic w_capture;

  // flush also frees the slot so the concurrent fetch packet is consumed.
  assign fetch_rdy = ~decode_vld | decode_rdy | flush;
  assign w_capture = fetch_vld & fetch_rdy & ~flush;

  logic [31:0] r_pc, r_ir, r_op1, r_op2, r_rs1, r_rs2, r_imm;
  logic [4:0]  r_rd;
  logic [3:0]  r_aluop;
  logic        r_rd_we, r_is_load, r_is_store, r_is_branch, r_is_jump;
  logic        r_illegal, r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= 32'h0;
      r_ir        <= 32'h0;
      r_op1       <= 32'h0;
      r_op2       <= 32'h0;
      r_rs1       <= 32'h0;
      r_rs2       <= 32'h0;
      r_imm       <= 32'h0;
      r_rd        <= 5'd0;
      r_aluop     <= 4'd0;
      r_rd_we     <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_is_jump   <= 1'b0;
      r_illegal   <= 1'b0;
      r_vld       <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; only validity is dropped.
      r_vld <= 1'b0;
    end else if (w_capture) begin
      r_pc        <= fetch_pc;
      r_ir        <= fetch_ir;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_imm       <= w_imm;
      r_rd        <= w_rd;
      r_aluop     <= w_aluop;
      r_rd_we     <= w_rd_we;
      r_is_load   <= w_is_load;
      r_is_store  <= w_is_store;
      r_is_branch <= w_is_branch;
      r_is_jump   <= w_is_jump;
      r_illegal   <= w_illegal;
      r_vld       <= 1'b1;
    end else if (r_vld && decode_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign decode_pc        = r_pc;
  assign decode_ir        = r_ir;
  assign decode_op1       = r_op1;
  assign decode_op2       = r_op2;
  assign decode_rs1_data  = r_rs1;
  assign decode_rs2_data  = r_rs2;
  assign decode_imm       = r_imm;
  assign decode_rd        = r_rd;
  assign decode_rd_we     = r_rd_we;
  assign decode_aluop     = r_aluop;
  assign decode_is_load   = r_is_load;
  assign decode_is_store  = r_is_store;
  assign decode_is_branch = r_is_branch;
  assign decode_is_jump   = r_is_jump;
  assign decode_illegal   = r_illegal;
  assign decode_vld       = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_kronos_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kronos_decode
//  Purpose  : Directed self-checking bench for kronos_decode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kronos_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc, fetch_ir;
  logic        fetch_vld, fetch_rdy;
  logic [4:0]  regrd_rs1_addr, regrd_rs2_addr;
  logic [31:0] regrd_rs1_data, regrd_rs2_data;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic        flush;
  logic [31:0] decode_pc, decode_ir, decode_op1, decode_op2;
  logic [31:0] decode_rs1_data, decode_rs2_data, decode_imm;
  logic [4:0]  decode_rd;
  logic        decode_rd_we;
  logic [3:0]  decode_aluop;
  logic        decode_is_load, decode_is_store, decode_is_branch, decode_is_jump;
  logic        decode_illegal, decode_vld, decode_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kronos_decode dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .fetch_ir(fetch_ir), .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
    .regrd_rs1_addr(regrd_rs1_addr), .regrd_rs2_addr(regrd_rs2_addr),
    .regrd_rs1_data(regrd_rs1_data), .regrd_rs2_data(regrd_rs2_data),
    .regwr_en(regwr_en), .regwr_sel(regwr_sel), .regwr_data(regwr_data),
    .flush(flush),
    .decode_pc(decode_pc), .decode_ir(decode_ir),
    .decode_op1(decode_op1), .decode_op2(decode_op2),
    .decode_rs1_data(decode_rs1_data), .decode_rs2_data(decode_rs2_data),
    .decode_imm(decode_imm), .decode_rd(decode_rd), .decode_rd_we(decode_rd_we),
    .decode_aluop(decode_aluop),
    .decode_is_load(decode_is_load), .decode_is_store(decode_is_store),
    .decode_is_branch(decode_is_branch), .decode_is_jump(decode_is_jump),
    .decode_illegal(decode_illegal), .decode_vld(decode_vld), .decode_rdy(decode_rdy)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_vld = 1'b1; fetch_ir = 32'h00500093; fetch_pc = 32'h40;
    flush = 1'b0; decode_rdy = 1'b0;
    step(); step();
    fetch_vld = 1'b0;
    #1;
    total++;
    if ({decode_vld, decode_pc, decode_ir, decode_op1, decode_op2, decode_imm} !== 161'd0) begin
      bad++;
      $display("FAIL reset_main got vld=%b pc=%h ir=%h op1=%h op2=%h imm=%h exp all 0",
               decode_vld, decode_pc, decode_ir, decode_op1, decode_op2, decode_imm);
    end
    total++;
    if ({decode_rd, decode_rd_we, decode_aluop, decode_is_load, decode_is_store,
         decode_is_branch, decode_is_jump, decode_illegal, decode_rs1_data, decode_rs2_data} !== 79'd0) begin
      bad++;
      $display("FAIL reset_ctrl got rd=%h we=%b aluop=%h flags=%b%b%b%b ill=%b exp all 0",
               decode_rd, decode_rd_we, decode_aluop, decode_is_load, decode_is_store,
               decode_is_branch, decode_is_jump, decode_illegal);
    end
    total++;
    if (fetch_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_fetch_rdy got=%b exp=1", fetch_rdy);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    decode_rdy = 1'b1; fetch_vld = 1'b1; fetch_ir = 32'h00500093; fetch_pc = 32'h100;
    #1;
    total++;
    if ({regrd_rs1_addr, regrd_rs2_addr} !== {5'd0, 5'd5}) begin
      bad++; $display("FAIL addi_rdaddr got=%h/%h exp=0/5", regrd_rs1_addr, regrd_rs2_addr);
    end
    step();
    fetch_vld = 1'b0;
    total++;
    if ({decode_vld, decode_op1, decode_op2, decode_imm, decode_pc} !== {1'b1, 32'h0, 32'h5, 32'h5, 32'h100}) begin
      bad++;
      $display("FAIL addi_data got vld=%b op1=%h op2=%h imm=%h pc=%h exp 1/0/5/5/100",
               decode_vld, decode_op1, decode_op2, decode_imm, decode_pc);
    end
    total++;
    if ({decode_rd, decode_rd_we, decode_aluop, decode_illegal} !== {5'd1, 1'b1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL addi_ctrl got rd=%0d we=%b aluop=%b ill=%b exp 1/1/0000/0",
               decode_rd, decode_rd_we, decode_aluop, decode_illegal);
    end
  endtask

  task automatic test_forward();
    // ADD x3,x2,x2 with writeback to x2 in the same cycle
    fetch_vld = 1'b1; fetch_ir = 32'h002101B3; fetch_pc = 32'h104;
    regrd_rs1_data = 32'h11; regrd_rs2_data = 32'h11;
    regwr_en = 1'b1; regwr_sel = 5'd2; regwr_data = 32'hDEADBEEF;
    step();
    total++;
    if ({decode_op1, decode_op2, decode_rs1_data, decode_rs2_data} !==
        {4{32'hDEADBEEF}}) begin
      bad++;
      $display("FAIL fwd_hit got op1=%h op2=%h rs1=%h rs2=%h exp deadbeef",
               decode_op1, decode_op2, decode_rs1_data, decode_rs2_data);
    end
    total++;
    if ({decode_rd, decode_rd_we, decode_aluop} !== {5'd3, 1'b1, 4'b0000}) begin
      bad++; $display("FAIL fwd_ctrl got rd=%0d we=%b aluop=%b exp 3/1/0000",
                      decode_rd, decode_rd_we, decode_aluop);
    end
    // Writeback to another register: file data used
    regwr_sel = 5'd5;
    step();
    total++;
    if ({decode_op1, decode_op2} !== {32'h11, 32'h11}) begin
      bad++; $display("FAIL fwd_miss got op1=%h op2=%h exp 11/11", decode_op1, decode_op2);
    end
    // ADD x3,x0,x0 with writeback to x0: must read zero
    fetch_ir = 32'h000001B3; regwr_sel = 5'd0;
    step();
    fetch_vld = 1'b0; regwr_en = 1'b0;
    total++;
    if ({decode_op1, decode_op2} !== 64'h0) begin
      bad++; $display("FAIL fwd_x0 got op1=%h op2=%h exp 0/0", decode_op1, decode_op2);
    end
  endtask

  task automatic test_backpressure();
    decode_rdy = 1'b1; fetch_vld = 1'b1; fetch_ir = 32'h00500093; fetch_pc = 32'h200;
    step();
    decode_rdy = 1'b0; fetch_ir = 32'h00700113; fetch_pc = 32'h204;  // ADDI x2,x0,7
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({fetch_rdy, decode_vld, decode_pc, decode_op2, decode_rd} !==
          {1'b0, 1'b1, 32'h200, 32'h5, 5'd1}) begin
        bad++;
        $display("FAIL stall_%0d got frdy=%b vld=%b pc=%h op2=%h rd=%0d exp 0/1/200/5/1",
                 i, fetch_rdy, decode_vld, decode_pc, decode_op2, decode_rd);
      end
      step();
    end
    decode_rdy = 1'b1;
    #1;
    total++;
    if (fetch_rdy !== 1'b1) begin
      bad++; $display("FAIL stall_release_rdy got=%b exp=1", fetch_rdy);
    end
    step();
    fetch_vld = 1'b0;
    total++;
    if ({decode_vld, decode_pc, decode_op2, decode_rd} !== {1'b1, 32'h204, 32'h7, 5'd2}) begin
      bad++;
      $display("FAIL stall_next got vld=%b pc=%h op2=%h rd=%0d exp 1/204/7/2",
               decode_vld, decode_pc, decode_op2, decode_rd);
    end
    step();
    total++;
    if (decode_vld !== 1'b0) begin
      bad++; $display("FAIL stall_nodup got vld=%b exp=0", decode_vld);
    end
  endtask

  task automatic test_back_to_back();
    // ir, op1, op2, imm, aluop, {rd_we,load,store,branch,jump}
    logic [31:0] t_ir  [7] = '{32'h40208033, 32'h4020D093, 32'hFE000EE3, 32'h0080A283,
                               32'h0020A623, 32'h123453B7, 32'h010000EF};
    logic [31:0] t_op1 [7] = '{32'h11, 32'h11, 32'h0, 32'h11, 32'h11, 32'h0, 32'h0};
    logic [31:0] t_op2 [7] = '{32'h22, 32'h402, 32'h0, 32'h8, 32'hC, 32'h12345000, 32'h4};
    logic [31:0] t_imm [7] = '{32'h0, 32'h402, 32'hFFFFFFFC, 32'h8, 32'hC, 32'h12345000, 32'h10};
    logic [3:0]  t_alu [7] = '{4'b1000, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [4:0]  t_flg [7] = '{5'b00000, 5'b10000, 5'b00010, 5'b11000, 5'b00100, 5'b10000, 5'b10001};
    logic [31:0] exp_op1;
    regrd_rs1_data = 32'h11; regrd_rs2_data = 32'h22; regwr_en = 1'b0;
    decode_rdy = 1'b1; fetch_vld = 1'b1;
    fetch_ir = t_ir[0]; fetch_pc = 32'h300;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i < 6) begin
        fetch_ir = t_ir[i+1]; fetch_pc = 32'h300 + 32'(4 * (i + 1));
      end else begin
        fetch_vld = 1'b0;
      end
      // JAL operand 1 is its own pc
      exp_op1 = (i == 6) ? 32'h300 + 32'(4 * i) : t_op1[i];
      total++;
      if ({decode_vld, decode_pc, decode_op1, decode_op2, decode_imm} !==
          {1'b1, 32'h300 + 32'(4 * i), exp_op1, t_op2[i], t_imm[i]}) begin
        bad++;
        $display("FAIL b2b_data_%0d got vld=%b pc=%h op1=%h op2=%h imm=%h exp 1/%h/%h/%h/%h",
                 i, decode_vld, decode_pc, decode_op1, decode_op2, decode_imm,
                 32'h300 + 32'(4 * i), exp_op1, t_op2[i], t_imm[i]);
      end
      total++;
      if ({decode_aluop, decode_rd_we, decode_is_load, decode_is_store, decode_is_branch,
           decode_is_jump, decode_illegal} !== {t_alu[i], t_flg[i], 1'b0}) begin
        bad++;
        $display("FAIL b2b_ctrl_%0d got aluop=%b flags=%b%b%b%b%b ill=%b exp %b/%b/0",
                 i, decode_aluop, decode_rd_we, decode_is_load, decode_is_store,
                 decode_is_branch, decode_is_jump, decode_illegal, t_alu[i], t_flg[i]);
      end
    end
    step();
  endtask

  task automatic test_illegal();
    // all-zero word, MUL (funct7=0000001), BEQ-space funct3=010, JALR funct3=001
    logic [31:0] t_ir [4] = '{32'h00000000, 32'h022081B3, 32'h0000A063, 32'h000090E7};
    decode_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_vld = 1'b1; fetch_ir = t_ir[i]; fetch_pc = 32'h400;
      step();
      fetch_vld = 1'b0;
      total++;
      if ({decode_illegal, decode_rd_we, decode_vld, decode_is_load, decode_is_store,
           decode_is_branch, decode_is_jump} !== 7'b1010000) begin
        bad++;
        $display("FAIL illegal_%0d got ill=%b we=%b vld=%b flags=%b%b%b%b exp 1/0/1/0000",
                 i, decode_illegal, decode_rd_we, decode_vld, decode_is_load,
                 decode_is_store, decode_is_branch, decode_is_jump);
      end
    end
    step();
  endtask

  task automatic test_flush();
    decode_rdy = 1'b1; fetch_vld = 1'b1; fetch_ir = 32'h00500093; fetch_pc = 32'h500;
    step();
    decode_rdy = 1'b0; flush = 1'b1; fetch_ir = 32'h00700113; fetch_pc = 32'h504;
    #1;
    total++;
    if ({decode_vld, fetch_rdy} !== 2'b11) begin
      bad++; $display("FAIL flush_rdy got vld=%b frdy=%b exp 1/1", decode_vld, fetch_rdy);
    end
    step();
    flush = 1'b0; fetch_vld = 1'b0;
    total++;
    if (decode_vld !== 1'b0) begin
      bad++; $display("FAIL flush_vld got=%b exp=0", decode_vld);
    end
    step();
    total++;
    if (decode_vld !== 1'b0) begin
      bad++; $display("FAIL flush_discard got=%b exp=0", decode_vld);
    end
  endtask

  task automatic test_reset_mid();
    decode_rdy = 1'b1; fetch_vld = 1'b1; fetch_ir = 32'h123453B7; fetch_pc = 32'h600;
    step();
    fetch_ir = 32'h010000EF; fetch_pc = 32'h604; rst = 1'b1;
    step();
    rst = 1'b0; fetch_vld = 1'b0;
    total++;
    if ({decode_vld, decode_pc, decode_ir, decode_op1, decode_op2, decode_imm,
         decode_rd, decode_rd_we, decode_is_jump} !== 168'd0) begin
      bad++;
      $display("FAIL rst_mid got vld=%b pc=%h ir=%h op1=%h op2=%h imm=%h rd=%0d we=%b j=%b exp all 0",
               decode_vld, decode_pc, decode_ir, decode_op1, decode_op2, decode_imm,
               decode_rd, decode_rd_we, decode_is_jump);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_pc = '0; fetch_ir = '0; fetch_vld = 1'b0; flush = 1'b0;
    regrd_rs1_data = '0; regrd_rs2_data = '0; regwr_en = 1'b0; regwr_sel = '0;
    regwr_data = '0; decode_rdy = 1'b0;
    test_reset();
    test_addi();
    test_forward();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kronos_decode.md
Name: kronos_decode

Overview:
- Instruction decode stage of the Kronos RV32I core. Sits directly downstream of instruction fetch and consumes its {pc, ir} valid/ready stream.
- Reads the register file and forwards the same-cycle writeback. Decodes RV32I into ALU operands, immediate and control flags.
- Presents one registered decode packet per instruction to execute over a valid/ready handshake.

Parameters:
- none

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- fetch_pc  in  32  PC of the offered instruction
- fetch_ir  in  32  instruction word
- fetch_vld  in  1  fetch packet valid
- fetch_rdy  out  1  decode can accept a packet this cycle
- regrd_rs1_addr  out  5  register file read address 1 (asynchronous read)
- regrd_rs2_addr  out  5  register file read address 2
- regrd_rs1_data  in  32  read data 1
- regrd_rs2_data  in  32  read data 2
- regwr_en  in  1  writeback write enable
- regwr_sel  in  5  writeback destination register
- regwr_data  in  32  writeback data
- flush  in  1  kill held and incoming instruction (branch taken)
- decode_pc, decode_ir  out  32 each  captured pc and ir
- decode_op1, decode_op2  out  32 each  ALU operands
- decode_rs1_data, decode_rs2_data  out  32 each  forwarded register values
- decode_imm  out  32  sign-extended immediate
- decode_rd  out  5  destination register
- decode_rd_we  out  1  destination write enable
- decode_aluop  out  4  ALU operation
- decode_is_load, decode_is_store, decode_is_branch, decode_is_jump  out  1 each  class flags
- decode_illegal  out  1  illegal instruction
- decode_vld  out  1  decode packet valid
- decode_rdy  in  1  execute accepts the packet

Behaviour:
- Reset (rst high at a clk edge): every decode_* output becomes 0, decode_vld becomes 0. Reset overrides flush and capture. Reset mid-packet drops the packet.
- Handshake:
  - fetch_rdy = ~decode_vld | decode_rdy | flush, combinational.
  - Capture happens when fetch_vld & fetch_rdy & ~flush. Latency is 1 cycle: decode_vld is high in the cycle after capture.
  - decode_vld clears when decode_vld & decode_rdy and there is no capture in that cycle.
  - The output packet is held stable while decode_vld & ~decode_rdy.
  - Back-to-back captures under continuous decode_rdy give 1 instruction per cycle.
- Flush: next cycle decode_vld=0. A concurrent fetch packet is consumed (fetch_rdy=1) and discarded. Data registers may keep stale values.
- Register read:
  - regrd_rs1_addr = fetch_ir[19:15] and regrd_rs2_addr = fetch_ir[24:20], combinational from fetch_ir.
  - rsN value: 0 if the address is 0; else regwr_data if regwr_en & regwr_sel==address; else regrd_rsN_data.
  - regwr_sel=0 never forwards.
- Immediates (all sign-extended from ir[31]): I for OP-IMM/LOAD/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL, 0 otherwise.
- Per-opcode decode:
  - LUI: op1=0, op2=imm, rd_we=1.
  - AUIPC: op1=pc, op2=imm, rd_we=1.
  - JAL and JALR: op1=pc, op2=4, rd_we=1, is_jump=1. JALR uses rs1_data as base downstream.
  - BRANCH: op1=rs1, op2=rs2, aluop={0,funct3}, is_branch=1, rd_we=0.
  - LOAD: op1=rs1, op2=imm, is_load=1, rd_we=1.
  - STORE: op1=rs1, op2=imm, is_store=1, rd_we=0.
  - OP-IMM: op1=rs1, op2=imm, aluop={ir[30] if funct3==101 else 0, funct3}, rd_we=1.
  - OP: op1=rs1, op2=rs2, aluop={ir[30],funct3}, rd_we=1.
  - MISC-MEM and SYSTEM: op1=op2=0, rd_we=0 (pass-through for later stages).
  - aluop is 0000 (add) wherever not stated above.
- decode_rd = ir[11:7] always. rd_we is forced to 0 when rd==0.
- Illegal conditions:
  - ir[1:0]!=11.
  - Unknown opcode.
  - BRANCH funct3 of 010 or 011.
  - LOAD funct3 of 011, 110 or 111.
  - STORE funct3 >= 011.
  - JALR funct3 != 000.
  - OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101.
  - OP-IMM shifts with a bad funct7.
- On an illegal instruction: illegal=1, rd_we=0, all class flags 0. The packet is still issued valid.

Test Plan:
- Reset, then fetch_vld=1 with ir=0x00500093 (ADDI x1,x0,5), pc=0x100 → next cycle decode_vld=1, op1=0, op2=5, imm=5, rd=1, rd_we=1, aluop=0, pc=0x100.
- ADD x3,x2,x2 (0x002101B3), with regwr_en=1, regwr_sel=2, regwr_data=0xDEADBEEF and regrd data 0x11 in the same cycle → op1=op2=0xDEADBEEF. Repeat with regwr_sel=0 and rs=x0 → op1=op2=0.
- decode_rdy=0 for 3 cycles with a new fetch packet pending → fetch_rdy=0, packet held unchanged. decode_rdy=1 → new packet appears next cycle with no loss or duplication.
- Streams of SUB (0x40208033), SRAI (0x4020D093), BEQ (0xFE000EE3), LW, SW, LUI, JAL → expected aluop 1000, 1101, 0000 with is_branch, is_load, is_store, U-immediate, is_jump, and op2=4 for JAL.
- ir=0x00000000, and OP with funct7=0000001 → decode_illegal=1, rd_we=0, decode_vld=1.
- flush asserted with decode_vld=1 and fetch_vld=1 → fetch_rdy=1, next cycle decode_vld=0. rst asserted mid-stream → all outputs 0 next cycle.
